led_flow_ctrl: RTL and testbench
================================

LED_FLOW_CTRL -- requirements
Module: led_flow_ctrl

Interface
REQ-001 SHALL have parameter N_LED, default 4, number of LED channels (legal range 2..32).
REQ-002 SHALL have parameter CNT_W, default 23, prescaler counter width.
REQ-003 SHALL have parameter T_STEP, default 5_000_000, clock cycles per pattern step (legal range 2..2^CNT_W-1).
REQ-004 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous and active-high; the only reset; one clock.
REQ-006 SHALL have port EN  input  1  run enable; low freezes all counters and blanks outputs.
REQ-007 SHALL have port MODE  input  2  pattern select: 0 OFF, 1 BLINK, 2 CHASE, 3 BOUNCE.
REQ-008 SHALL have port ON_CNT  input  CNT_W  BLINK on-time in cycles within each step.
REQ-009 SHALL have port LED_out  output  N_LED  registered LED drive, 1 = lit.
REQ-010 SHALL have port STEP_P  output  1  one-cycle pulse on the last cycle of each step.

Function
REQ-011 Prescaler SHALL count 0..T_STEP-1 and wrap to 0; STEP_P SHALL be high exactly when count == T_STEP-1 and EN=1.
REQ-012 Position register pos (0..N_LED-1) and direction bit dir (0 = up) SHALL update only when STEP_P is high.
REQ-013 OFF: LED_out SHALL be all zeros; pos and dir SHALL hold at 0.
REQ-014 BLINK: all LED_out bits SHALL be 1 while count < ON_CNT, else 0; ON_CNT=0 gives always off; ON_CNT >= T_STEP gives always on.
REQ-015 CHASE: LED_out SHALL be one-hot at bit pos; pos SHALL increment each step and wrap from N_LED-1 to 0.
REQ-016 BOUNCE: LED_out SHALL be one-hot at bit pos; pos SHALL move up to N_LED-1, then down to 0, then up again; the end LEDs SHALL be lit for one step each per reversal (sequence for N_LED=4: 0,1,2,3,2,1,0,1,...).
REQ-017 LED_out SHALL be registered: it reflects count, pos and MODE sampled on the previous edge (one-cycle latency).
REQ-018 A MODE change (MODE differs from its registered copy) SHALL clear count, pos and dir on the next edge; the new pattern then starts from pos 0 with a full step.
REQ-019 EN=0 SHALL hold count, pos and dir, force LED_out to 0 on the next edge and suppress STEP_P; EN returning to 1 SHALL resume from the held state.
REQ-020 ON_CNT SHALL be sampled combinationally every cycle; a change mid-step SHALL take effect on the next cycle.
REQ-021 When MODE change and the step boundary coincide, the MODE-change clear (REQ-018) SHALL take priority.

Reset
REQ-022 While RST=1 at an edge: count=0, pos=0, dir=0, registered MODE=0, LED_out=0, STEP_P=0.
REQ-023 RST SHALL override EN and MODE; asserting it mid-step SHALL abandon the step with no STEP_P pulse.

Structure
REQ-024 Mode encodings (OFF/BLINK/CHASE/BOUNCE) SHALL be constants in the shared package led_pkg.
REQ-025 The prescaler plus STEP_P generation SHALL be a sub-module led_tick_gen (params CNT_W, T_STEP; ports CLK, RST, EN, CLR, count, STEP_P).
REQ-026 Pattern logic (pos, dir, LED decode) SHALL live in led_flow_ctrl; no other sub-modules.

Verification (N_LED=4, CNT_W=4, T_STEP=4 unless stated)
REQ-027 Reset: hold RST 3 cycles with EN=1, MODE=2 -> LED_out=0000 and STEP_P=0 throughout; first STEP_P 4 cycles after release.
REQ-028 CHASE: MODE=2, EN=1 for 20 cycles -> LED_out 0001,0010,0100,1000,0001, each held 4 cycles; STEP_P every 4th cycle.
REQ-029 BOUNCE: MODE=3 for 32 cycles -> lit bit index 0,1,2,3,2,1,0,1, each held 4 cycles.
REQ-030 BLINK: MODE=1, ON_CNT=1 -> LED_out 1111 one cycle then 0000 three cycles, repeating; ON_CNT=0 -> constant 0000; ON_CNT=15 -> constant 1111.
REQ-031 EN/MODE: in CHASE at pos 2, drop EN 5 cycles -> LED_out 0000, no STEP_P, then resumes at 0100 with the remaining step cycles; switch MODE 2->3 on a STEP_P cycle -> restart at 0001 with a full 4-cycle step.

Source files
------------

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared pattern-mode encodings for the LED flow controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

   localparam logic [1:0] c_MODE_OFF    = 2'd0;
   localparam logic [1:0] c_MODE_BLINK  = 2'd1;
   localparam logic [1:0] c_MODE_CHASE  = 2'd2;
   localparam logic [1:0] c_MODE_BOUNCE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_tick_gen
//  Description : Step prescaler counting 0..T_STEP-1 with end-of-step pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_tick_gen #(
   parameter int CNT_W  = 23,
   parameter int T_STEP = 5_000_000
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             CLR,
   output logic [CNT_W-1:0] count,
   output logic             STEP_P
);

   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(T_STEP - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             last;

   assign last = (count_q == c_LAST);

   // CLR wins over EN so a pattern change always restarts with a full step
   always_comb begin
      count_d = count_q;
      if (CLR) begin
         count_d = '0;
      end else if (EN) begin
         count_d = last ? '0 : count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count  = count_q;
   assign STEP_P = EN & ~RST & last;

endmodule
`default_nettype wire

// File: rtl/led_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_flow_ctrl
//  Description : LED pattern generator (off / blink / chase / bounce).
//  Revision    : 1.0 - initial release
// ============================================================================
module led_flow_ctrl
   import led_pkg::*;
#(
   parameter int N_LED  = 4,
   parameter int CNT_W  = 23,
   parameter int T_STEP = 5_000_000
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic [1:0]       MODE,
   input  logic [CNT_W-1:0] ON_CNT,
   output logic [N_LED-1:0] LED_out,
   output logic             STEP_P
);

   localparam int                 c_POS_W   = $clog2(N_LED);
   localparam logic [c_POS_W-1:0] c_POS_MAX = c_POS_W'(N_LED - 1);

   logic [1:0]         mode_q;
   logic [c_POS_W-1:0] pos_q;
   logic [c_POS_W-1:0] pos_d;
   logic               dir_q;
   logic               dir_d;
   logic [N_LED-1:0]   led_q;
   logic [N_LED-1:0]   led_d;

   logic               mode_chg;
   logic [CNT_W-1:0]   count;
   logic               step_p;
   logic [N_LED-1:0]   onehot;

   assign mode_chg = (MODE != mode_q);

   led_tick_gen #(
      .CNT_W  (CNT_W),
      .T_STEP (T_STEP)
   ) u_tick (
      .CLK    (CLK),
      .RST    (RST),
      .EN     (EN),
      .CLR    (mode_chg),
      .count  (count),
      .STEP_P (step_p)
   );

   assign STEP_P = step_p;

   // Mode-change clear has priority over a coinciding step boundary
   always_comb begin
      pos_d = pos_q;
      dir_d = dir_q;
      if (mode_chg || mode_q == c_MODE_OFF) begin
         pos_d = '0;
         dir_d = 1'b0;
      end else if (step_p) begin
         case (mode_q)
            c_MODE_CHASE: begin
               pos_d = (pos_q == c_POS_MAX) ? '0 : pos_q + c_POS_W'(1);
               dir_d = 1'b0;
            end
            c_MODE_BOUNCE: begin
               if (!dir_q) begin
                  if (pos_q == c_POS_MAX) begin
                     dir_d = 1'b1;
                     pos_d = pos_q - c_POS_W'(1);
                  end else begin
                     pos_d = pos_q + c_POS_W'(1);
                  end
               end else begin
                  if (pos_q == '0) begin
                     dir_d = 1'b0;
                     pos_d = c_POS_W'(1);
                  end else begin
                     pos_d = pos_q - c_POS_W'(1);
                  end
               end
            end
            default: begin
               pos_d = pos_q;
               dir_d = dir_q;
            end
         endcase
      end
   end

   assign onehot = {{(N_LED-1){1'b0}}, 1'b1} << pos_q;

   // Decode uses the registered mode/state, giving exactly one cycle of latency
   always_comb begin
      led_d = '0;
      if (EN) begin
         case (mode_q)
            c_MODE_BLINK:  led_d = (count < ON_CNT) ? '1 : '0;
            c_MODE_CHASE:  led_d = onehot;
            c_MODE_BOUNCE: led_d = onehot;
            default:       led_d = '0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         mode_q <= c_MODE_OFF;
         pos_q  <= '0;
         dir_q  <= 1'b0;
         led_q  <= '0;
      end else begin
         mode_q <= MODE;
         pos_q  <= pos_d;
         dir_q  <= dir_d;
         led_q  <= led_d;
      end
   end

   assign LED_out = led_q;

endmodule
`default_nettype wire

// File: tb/tb_led_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_flow_ctrl
//  Description : Scoreboard bench for led_flow_ctrl (N_LED=4, CNT_W=4, T_STEP=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_flow_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic       EN;
   logic [1:0] MODE;
   logic [3:0] ON_CNT;
   logic [3:0] LED_out;
   logic       STEP_P;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] led;
      logic       stp;
      int         tag;
   } exp_t;

   exp_t sb[$];

   led_flow_ctrl #(
      .N_LED  (4),
      .CNT_W  (4),
      .T_STEP (4)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .EN      (EN),
      .MODE    (MODE),
      .ON_CNT  (ON_CNT),
      .LED_out (LED_out),
      .STEP_P  (STEP_P)
   );

   always #5 CLK = ~CLK;

   // Monitor: one expected entry per cycle, sampled mid-cycle on the falling edge
   always @(negedge CLK) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (LED_out !== e.led) begin
            failures++;
            $display("FAIL led tag=%0d got=%b exp=%b", e.tag, LED_out, e.led);
         end
         checks++;
         if (STEP_P !== e.stp) begin
            failures++;
            $display("FAIL step_p tag=%0d got=%b exp=%b", e.tag, STEP_P, e.stp);
         end
      end
   end

   // Drive inputs for the next edge and queue the outputs expected this cycle
   task automatic drive(input logic rst, input logic en, input logic [1:0] mode,
                        input logic [3:0] on, input logic [3:0] e_led,
                        input logic e_stp, input int tag);
      exp_t e;
      RST    = rst;
      EN     = en;
      MODE   = mode;
      ON_CNT = on;
      e.led  = e_led;
      e.stp  = e_stp;
      e.tag  = tag;
      sb.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   function automatic int blink_on(input int j);
      if (j < 12) return 1;
      if (j < 24) return 0;
      return 15;
   endfunction

   initial begin
      logic [3:0] one;
      logic [3:0] led;
      int         btbl[6];
      btbl = '{0, 1, 2, 3, 2, 1};
      one  = 4'b0001;

      RST = 1'b1; EN = 1'b1; MODE = 2'd2; ON_CNT = 4'd0;
      @(posedge CLK);
      #1;

      // Reset held three edges with EN=1, MODE=CHASE
      drive(1'b1, 1'b1, 2'd2, 4'd0, 4'b0000, 1'b0, 1);
      drive(1'b1, 1'b1, 2'd2, 4'd0, 4'b0000, 1'b0, 2);
      drive(1'b0, 1'b1, 2'd2, 4'd0, 4'b0000, 1'b0, 3);

      // CHASE: first edge after release clears (mode 0 -> 2), then 4-cycle steps
      for (int j = 0; j <= 26; j++) begin
         led = (j == 0) ? 4'b0000 : (one << (((j - 1) / 4) % 4));
         drive(1'b0, 1'b1, 2'd2, 4'd0, led, (j % 4) == 3, 1000 + j);
      end
      // EN dropped on the last cycle of the pos-2 step: pulse suppressed, state held
      drive(1'b0, 1'b0, 2'd2, 4'd0, 4'b0100, 1'b0, 1027);
      for (int j = 28; j <= 31; j++)
         drive(1'b0, 1'b0, 2'd2, 4'd0, 4'b0000, 1'b0, 1000 + j);
      drive(1'b0, 1'b1, 2'd2, 4'd0, 4'b0000, 1'b1, 1032);
      drive(1'b0, 1'b1, 2'd2, 4'd0, 4'b0100, 1'b0, 1033);
      drive(1'b0, 1'b1, 2'd2, 4'd0, 4'b1000, 1'b0, 1034);
      drive(1'b0, 1'b1, 2'd2, 4'd0, 4'b1000, 1'b0, 1035);
      // MODE 2->3 on a STEP_P cycle
      drive(1'b0, 1'b1, 2'd3, 4'd0, 4'b1000, 1'b1, 1036);

      // BOUNCE from pos 0 with a full step; last call switches to BLINK
      for (int j = 0; j <= 32; j++) begin
         led = (j == 0) ? 4'b1000 : (one << btbl[((j - 1) / 4) % 6]);
         drive(1'b0, 1'b1, (j == 32) ? 2'd1 : 2'd3, (j == 32) ? 4'd1 : 4'd0,
               led, (j % 4) == 3, 2000 + j);
      end

      // BLINK with ON_CNT = 1, then 0, then 15; last call switches to OFF
      for (int j = 0; j <= 35; j++) begin
         if (j == 0)
            led = 4'b0100;
         else
            led = (((j - 1) % 4) < blink_on(j - 1)) ? 4'b1111 : 4'b0000;
         drive(1'b0, 1'b1, (j == 35) ? 2'd0 : 2'd1, 4'(blink_on(j)),
               led, (j % 4) == 3, 3000 + j);
      end

      // OFF: LEDs dark, prescaler keeps pulsing; reset lands on a last-count cycle
      for (int j = 0; j <= 6; j++) begin
         led = (j == 0) ? 4'b1111 : 4'b0000;
         drive(1'b0, 1'b1, 2'd0, 4'd15, led, (j % 4) == 3, 4000 + j);
      end
      drive(1'b1, 1'b1, 2'd0, 4'd15, 4'b0000, 1'b0, 4007);
      drive(1'b0, 1'b1, 2'd0, 4'd15, 4'b0000, 1'b0, 4008);

      repeat (3) @(posedge CLK);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
